// File: rtl/udma_spim_cmd_arb_if.sv
// Command-channel bundle between the requesters, the arbiter and the SPI master.
// The slave side is the arbiter; the master side drives requests and cmd_ready.
interface udma_spim_cmd_arb_if #(
    parameter int N_REQ = 2
);
    logic [N_REQ-1:0][31:0] req_cmd;
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [31:0]            cmd;
    logic                   cmd_valid;
    logic                   cmd_ready;

    modport slave (
        input  req_cmd,
        input  req_valid,
        output req_ready,
        output cmd,
        output cmd_valid,
        input  cmd_ready
    );

    modport master (
        output req_cmd,
        output req_valid,
        input  req_ready,
        input  cmd,
        input  cmd_valid,
        output cmd_ready
    );
endinterface

// File: rtl/udma_spim_cmd_arb.sv
// Round-robin lock arbiter for the SPI-master command channel.
// An owner keeps the channel until its EOT word or a stall timeout.
module udma_spim_cmd_arb #(
    parameter int         N_REQ      = 2,
    parameter int         TIMEOUT_W  = 16,
    parameter logic [3:0] EOT_OPCODE = 4'h9
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    udma_spim_cmd_arb_if.slave   bus,
    input  logic [TIMEOUT_W-1:0] cfg_timeout_i,
    output logic [N_REQ-1:0]     grant_o,
    output logic                 busy_o,
    output logic                 timeout_evt_o
);
    localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    logic [0:0]           state;
    logic [OW-1:0]        owner;
    logic [OW-1:0]        rr_ptr;
    logic [TIMEOUT_W-1:0] stall_cnt;
    logic                 timeout_evt;

    logic [OW-1:0] pick;
    logic [OW-1:0] nxt_ptr;
    logic          found;
    int            idx;
    logic          owner_valid;
    logic          hs;
    logic          eot;
    logic          stall;
    logic          to_en;
    logic          to_fire;

    // First valid requester at or after rr_ptr, wrapping modulo N_REQ
    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = (int'(rr_ptr) + i) % N_REQ;
            if (!found && bus.req_valid[idx]) begin
                found = 1'b1;
                pick  = OW'(idx);
            end
        end
    end

    assign nxt_ptr = (owner == OW'(N_REQ - 1)) ? '0 : owner + OW'(1);

    always_comb begin
        bus.cmd       = '0;
        bus.cmd_valid = 1'b0;
        bus.req_ready = '0;
        grant_o       = '0;
        if (state == LOCKED) begin
            bus.cmd              = bus.req_cmd[owner];
            bus.cmd_valid        = bus.req_valid[owner];
            bus.req_ready[owner] = bus.cmd_ready;
            grant_o[owner]       = 1'b1;
        end
    end

    assign owner_valid = bus.req_valid[owner];
    assign hs          = bus.cmd_valid & bus.cmd_ready;
    assign eot         = hs && (bus.cmd[31:28] == EOT_OPCODE);
    assign stall       = (state == LOCKED) && !owner_valid;
    assign to_en       = (cfg_timeout_i != '0);

    // >= so a lowered limit releases at once instead of wrapping the counter
    assign to_fire = stall && to_en &&
                     (stall_cnt >= cfg_timeout_i - TIMEOUT_W'(1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            owner       <= '0;
            rr_ptr      <= '0;
            stall_cnt   <= '0;
            timeout_evt <= 1'b0;
        end else begin
            timeout_evt <= 1'b0;
            if (state == IDLE) begin
                stall_cnt <= '0;
                if (found) begin
                    state <= LOCKED;
                    owner <= pick;
                end
            end else if (eot) begin
                state     <= IDLE;
                rr_ptr    <= nxt_ptr;
                stall_cnt <= '0;
            end else if (to_fire) begin
                state       <= IDLE;
                rr_ptr      <= nxt_ptr;
                stall_cnt   <= '0;
                timeout_evt <= 1'b1;
            end else if (stall && to_en) begin
                stall_cnt <= stall_cnt + TIMEOUT_W'(1);
            end else begin
                stall_cnt <= '0;
            end
        end
    end

    assign busy_o        = (state == LOCKED);
    assign timeout_evt_o = timeout_evt;

endmodule

// File: tb/tb_udma_spim_cmd_arb.sv
// Scoreboard bench for udma_spim_cmd_arb: randomized and directed transactions
// checked cycle by cycle against a transaction-level reference model.
module tb_udma_spim_cmd_arb;
    localparam int         N   = 3;
    localparam logic [3:0] EOT = 4'h9;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cfg;
    logic [N-1:0] grant_o;
    logic        busy_o;
    logic        timeout_evt_o;

    udma_spim_cmd_arb_if #(.N_REQ(N)) bus ();

    udma_spim_cmd_arb #(
        .N_REQ(N),
        .TIMEOUT_W(16),
        .EOT_OPCODE(EOT)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus(bus),
        .cfg_timeout_i(cfg),
        .grant_o(grant_o),
        .busy_o(busy_o),
        .timeout_evt_o(timeout_evt_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int evt_seen = 0;

    logic [31:0] words [N][$];
    logic [31:0] exp_q [N][$];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic bit pending();
        bit p = 1'b0;
        for (int r = 0; r < N; r++)
            if (words[r].size() != 0) p = 1'b1;
        return p;
    endfunction

    task automatic gen_txn(int r, int len);
        logic [31:0] w;
        int x;
        for (int j = 0; j < len; j++) begin
            x = $urandom_range(0, 14);
            if (x >= 9) x++;
            if (j == len - 1) x = int'(EOT);
            w = {x[3:0], 28'($urandom)};
            words[r].push_back(w);
            exp_q[r].push_back(w);
        end
    endtask

    // Reference model: owner locks until its EOT word is accepted or it
    // has been silent for cfg consecutive cycles; grants go round-robin.
    task automatic monitor();
        bit          m_locked = 1'b0;
        bit          m_evt = 1'b0;
        int          m_owner = 0;
        int          m_rr = 0;
        int          m_stall = 0;
        int          k;
        logic [31:0] w;
        logic [N-1:0] eg;
        logic [N-1:0] er;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_locked = 1'b0;
                m_evt    = 1'b0;
                m_owner  = 0;
                m_rr     = 0;
                m_stall  = 0;
                continue;
            end
            eg = m_locked ? (N'(1) << m_owner) : '0;
            er = (m_locked && bus.cmd_ready) ? eg : '0;
            chk("busy", 32'(busy_o), 32'(m_locked));
            chk("grant", 32'(grant_o), 32'(eg));
            chk("timeout_evt", 32'(timeout_evt_o), 32'(m_evt));
            chk("cmd_valid", 32'(bus.cmd_valid),
                32'(m_locked && bus.req_valid[m_owner]));
            chk("req_ready", 32'(bus.req_ready), 32'(er));
            if (!m_locked) chk("idle_cmd", bus.cmd, 32'h0);
            m_evt = 1'b0;
            if (m_locked) begin
                if (bus.req_valid[m_owner] && bus.cmd_ready) begin
                    m_stall = 0;
                    if (exp_q[m_owner].size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_word actual=%h required=none",
                                 bus.cmd);
                        w = bus.cmd;
                    end else begin
                        w = exp_q[m_owner].pop_front();
                        chk("cmd_word", bus.cmd, w);
                    end
                    if (w[31:28] == EOT) begin
                        m_locked = 1'b0;
                        m_rr     = (m_owner + 1) % N;
                    end
                end else if (!bus.req_valid[m_owner] && cfg != 0) begin
                    m_stall++;
                    if (m_stall >= int'(cfg)) begin
                        m_locked = 1'b0;
                        m_rr     = (m_owner + 1) % N;
                        m_evt    = 1'b1;
                        m_stall  = 0;
                    end
                end else begin
                    m_stall = 0;
                end
            end else begin
                for (int i = 0; i < N; i++) begin
                    k = (m_rr + i) % N;
                    if (!m_locked && bus.req_valid[k]) begin
                        m_locked = 1'b1;
                        m_owner  = k;
                    end
                end
            end
        end
    endtask

    task automatic auto_run(int max_cyc, bit gaps, bit rnd_rdy);
        int          n = 0;
        int          gapc [N];
        logic [N-1:0] fired;
        for (int r = 0; r < N; r++) gapc[r] = 0;
        while (n < max_cyc && (pending() || busy_o)) begin
            @(negedge clk);
            fired = bus.req_valid & bus.req_ready;
            @(posedge clk);
            #1;
            for (int r = 0; r < N; r++) begin
                if (fired[r]) void'(words[r].pop_front());
                if (words[r].size() == 0) begin
                    bus.req_valid[r] = 1'b0;
                end else if (!(bus.req_valid[r] && !fired[r])) begin
                    if (gaps && gapc[r] < 2 && $urandom_range(0, 3) == 0) begin
                        bus.req_valid[r] = 1'b0;
                        gapc[r]++;
                    end else begin
                        bus.req_valid[r] = 1'b1;
                        bus.req_cmd[r]   = words[r][0];
                        gapc[r]          = 0;
                    end
                end
            end
            bus.cmd_ready = rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
            n++;
        end
        chk("auto_run_in_budget", 32'(n < max_cyc), 32'd1);
    endtask

    task automatic drain(int max_cyc);
        int          n = 0;
        logic [N-1:0] hs;
        while (n < max_cyc && bus.req_valid != '0) begin
            @(negedge clk);
            hs = bus.req_valid & bus.req_ready;
            if (timeout_evt_o) evt_seen++;
            @(posedge clk);
            #1;
            bus.req_valid = bus.req_valid & ~hs;
            n++;
        end
        chk("drain_in_budget", 32'(n < max_cyc), 32'd1);
    endtask

    logic [31:0] w;

    initial begin
        rst           = 1'b1;
        cfg           = 16'd8;
        bus.req_valid = '0;
        bus.req_cmd   = '0;
        bus.cmd_ready = 1'b0;
        fork
            monitor();
        join_none
        #1;
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_grant", 32'(grant_o), 32'd0);
        chk("rst_cmd_valid", 32'(bus.cmd_valid), 32'd0);
        chk("rst_cmd", bus.cmd, 32'd0);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_evt", 32'(timeout_evt_o), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // contention from reset, then a second round after the pointer wraps
        gen_txn(0, 2);
        gen_txn(1, 3);
        auto_run(100, 1'b0, 1'b0);
        gen_txn(0, 1);
        gen_txn(1, 2);
        auto_run(100, 1'b0, 1'b0);

        // single requester, three words
        gen_txn(0, 3);
        auto_run(100, 1'b0, 1'b0);

        // randomized traffic with gaps and backpressure
        for (int t = 0; t < 6; t++)
            for (int r = 0; r < N; r++)
                gen_txn(r, 1 + $urandom_range(0, 3));
        auto_run(4000, 1'b1, 1'b1);
        bus.cmd_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // backpressure does not count as stall; silence does
        cfg              = 16'd4;
        bus.req_cmd[0]   = {4'h1, 28'h0abcdef};
        bus.req_valid[0] = 1'b1;
        repeat (11) @(posedge clk);
        #1;
        chk("bp_still_locked", 32'(busy_o), 32'd1);
        evt_seen         = 0;
        bus.req_valid[0] = 1'b0;
        bus.cmd_ready    = 1'b1;
        w                = {EOT, 28'h1234567};
        exp_q[1].push_back(w);
        bus.req_cmd[1]   = w;
        bus.req_valid[1] = 1'b1;
        drain(20);
        chk("bp_evt_pulses", 32'(evt_seen), 32'd1);
        repeat (2) @(posedge clk);
        #1;

        // timeout disabled: owner silent for 1000 cycles
        cfg = 16'd0;
        w   = {4'h2, 28'($urandom)};
        exp_q[0].push_back(w);
        bus.req_cmd[0]   = w;
        bus.req_valid[0] = 1'b1;
        drain(10);
        evt_seen = 0;
        repeat (1000) begin
            @(negedge clk);
            if (timeout_evt_o) evt_seen++;
        end
        chk("dis_still_busy", 32'(busy_o), 32'd1);
        chk("dis_no_evt", 32'(evt_seen), 32'd0);
        @(posedge clk);
        #1;
        w = {EOT, 28'($urandom)};
        exp_q[0].push_back(w);
        bus.req_cmd[0]   = w;
        bus.req_valid[0] = 1'b1;
        drain(10);
        repeat (2) @(posedge clk);
        #1;

        // reset while locked
        cfg              = 16'd8;
        bus.cmd_ready    = 1'b0;
        bus.req_cmd[0]   = {4'h3, 28'h5555555};
        bus.req_valid[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("mid_locked", 32'(busy_o), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(busy_o), 32'd0);
        chk("mid_rst_grant", 32'(grant_o), 32'd0);
        chk("mid_rst_cmd_valid", 32'(bus.cmd_valid), 32'd0);
        chk("mid_rst_cmd", bus.cmd, 32'd0);
        chk("mid_rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("mid_rst_evt", 32'(timeout_evt_o), 32'd0);
        for (int r = 0; r < N; r++) exp_q[r].delete();
        bus.req_valid[0] = 1'b0;
        for (int r = 1; r < N; r++) begin
            w = {EOT, 28'(r)};
            exp_q[r].push_back(w);
            bus.req_cmd[r]   = w;
            bus.req_valid[r] = 1'b1;
        end
        bus.cmd_ready = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        drain(30);
        repeat (3) @(posedge clk);
        #1;

        for (int r = 0; r < N; r++)
            chk("exp_q_empty", 32'(exp_q[r].size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
